// File: rtl/c_v_pkg.sv
// Shared types for the streaming unary-code detector: FSM state and the
// running per-vector scan state carried from beat to beat.
package c_v_pkg;

  typedef enum logic {
    S_ACC = 1'b0,
    S_RES = 1'b1
  } state_e;

  // std_*: vector so far looks like ones-then-zeros; cmp_*: zeros-then-ones.
  // count: length of the initial run of bits equal to vector bit 0.
  typedef struct packed {
    logic        std_ok;
    logic        std_edge;
    logic        cmp_ok;
    logic        cmp_edge;
    int unsigned count;
  } carry_t;

  localparam carry_t CARRY_INIT = '{
    std_ok:   1'b1,
    std_edge: 1'b0,
    cmp_ok:   1'b1,
    cmp_edge: 1'b0,
    count:    0
  };

endpackage

// File: rtl/c_v_stream_beat.sv
// Combinational scanner: folds one C-bit beat (LSB first) into the running
// unary-code carry state.
module c_v_stream_beat
  import c_v_pkg::*;
#(
  parameter int unsigned C = 4
) (
  input  logic [C-1:0] dat,
  input  carry_t       carry_in,
  output carry_t       carry_out
);

  carry_t c;

  always_comb begin
    c = carry_in;
    for (int unsigned i = 0; i < C; i++) begin
      // The initial run only grows until the opposite bit value first appears.
      if ((dat[i] && !c.std_edge) || (!dat[i] && !c.cmp_edge)) begin
        c.count = c.count + 1;
      end
      c.std_ok   = c.std_ok & ~(dat[i] & c.std_edge);
      c.cmp_ok   = c.cmp_ok & ~(~dat[i] & c.cmp_edge);
      c.std_edge = c.std_edge | ~dat[i];
      c.cmp_edge = c.cmp_edge | dat[i];
    end
    carry_out = c;
  end

endmodule

// File: rtl/c_v_stream.sv
// Streaming unary-code detector: collects W/C beats into one vector and
// reports standard / complemented unary match, length and all-ones.
module c_v_stream
  import c_v_pkg::*;
#(
  parameter int unsigned W               = 16,
  parameter int unsigned C               = 4,
  parameter int unsigned P_IS_COMPLIMENT = 1
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 i_in_vld,
  input  logic [C-1:0]         i_in_dat,
  input  logic                 i_cmp_en,
  input  logic                 i_flush,
  input  logic                 i_res_rdy,
  output logic                 o_in_rdy,
  output logic                 o_res_vld,
  output logic                 o_is_unary,
  output logic                 o_all_set,
  output logic                 o_is_cmp,
  output logic [$clog2(W)-1:0] o_len
);

  localparam int unsigned N      = W / C;
  localparam int unsigned BCNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LEN_W  = $clog2(W);

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  carry_t              carry_q, carry_d;
  logic                mode_q, mode_d;
  logic                res_vld_d, is_unary_d, all_set_d, is_cmp_d;
  logic [LEN_W-1:0]    len_d;

  carry_t              scan_in, scan_out;
  logic                accept, first_beat, last_beat, mode_eff;
  logic                std_m, cmp_m;

  assign o_in_rdy   = !i_flush && ((state_q == S_ACC) || ((state_q == S_RES) && i_res_rdy));
  assign accept     = i_in_vld && o_in_rdy;
  // Counter is held at zero in S_RES, so a beat taken during a pop is beat 0.
  assign first_beat = (bcnt_q == '0);
  assign last_beat  = (bcnt_q == BCNT_W'(N - 1));
  assign scan_in    = first_beat ? CARRY_INIT : carry_q;
  assign mode_eff   = first_beat ? i_cmp_en : mode_q;

  c_v_stream_beat #(.C(C)) u_beat (
    .dat       (i_in_dat),
    .carry_in  (scan_in),
    .carry_out (scan_out)
  );

  assign std_m = scan_out.std_ok && scan_out.std_edge;
  assign cmp_m = (P_IS_COMPLIMENT != 0) && mode_eff && scan_out.cmp_ok && scan_out.cmp_edge;

  // Next-state and result computation.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    carry_d    = carry_q;
    mode_d     = mode_q;
    res_vld_d  = o_res_vld;
    is_unary_d = o_is_unary;
    all_set_d  = o_all_set;
    is_cmp_d   = o_is_cmp;
    len_d      = o_len;

    if (i_flush) begin
      state_d    = S_ACC;
      bcnt_d     = '0;
      res_vld_d  = 1'b0;
      is_unary_d = 1'b0;
      all_set_d  = 1'b0;
      is_cmp_d   = 1'b0;
      len_d      = '0;
    end else if (accept) begin
      carry_d = scan_out;
      if (first_beat) begin
        mode_d = i_cmp_en;
      end
      if (last_beat) begin
        state_d    = S_RES;
        bcnt_d     = '0;
        res_vld_d  = 1'b1;
        is_unary_d = std_m || cmp_m;
        all_set_d  = scan_out.std_ok && !scan_out.std_edge;
        is_cmp_d   = cmp_m;
        // A run spanning the whole vector only matches with length zero.
        len_d      = ((std_m || cmp_m) && (scan_out.count != W)) ?
                     LEN_W'(scan_out.count) : '0;
      end else begin
        state_d    = S_ACC;
        bcnt_d     = bcnt_q + BCNT_W'(1);
        res_vld_d  = 1'b0;
        is_unary_d = 1'b0;
        all_set_d  = 1'b0;
        is_cmp_d   = 1'b0;
        len_d      = '0;
      end
    end else if ((state_q == S_RES) && i_res_rdy) begin
      state_d    = S_ACC;
      bcnt_d     = '0;
      res_vld_d  = 1'b0;
      is_unary_d = 1'b0;
      all_set_d  = 1'b0;
      is_cmp_d   = 1'b0;
      len_d      = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_ACC;
      bcnt_q     <= '0;
      carry_q    <= '0;
      mode_q     <= 1'b0;
      o_res_vld  <= 1'b0;
      o_is_unary <= 1'b0;
      o_all_set  <= 1'b0;
      o_is_cmp   <= 1'b0;
      o_len      <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      carry_q    <= carry_d;
      mode_q     <= mode_d;
      o_res_vld  <= res_vld_d;
      o_is_unary <= is_unary_d;
      o_all_set  <= all_set_d;
      o_is_cmp   <= is_cmp_d;
      o_len      <= len_d;
    end
  end

endmodule

// File: tb/tb_c_v_stream.sv
// Bench for c_v_stream: vector-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_c_v_stream;

  localparam int unsigned W  = 16;
  localparam int unsigned C  = 4;
  localparam int unsigned N  = W / C;
  localparam int unsigned LW = $clog2(W);

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          i_in_vld = 1'b0;
  logic [C-1:0]  i_in_dat = '0;
  logic          i_cmp_en = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_res_rdy = 1'b1;

  logic          o_in_rdy, o_res_vld, o_is_unary, o_all_set, o_is_cmp;
  logic [LW-1:0] o_len;
  logic          p0_in_rdy, p0_res_vld, p0_is_unary, p0_all_set, p0_is_cmp;
  logic [LW-1:0] p0_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  c_v_stream #(.W(W), .C(C), .P_IS_COMPLIMENT(1)) dut (
    .clk(clk), .arst_n(arst_n), .i_in_vld(i_in_vld), .i_in_dat(i_in_dat),
    .i_cmp_en(i_cmp_en), .i_flush(i_flush), .i_res_rdy(i_res_rdy),
    .o_in_rdy(o_in_rdy), .o_res_vld(o_res_vld), .o_is_unary(o_is_unary),
    .o_all_set(o_all_set), .o_is_cmp(o_is_cmp), .o_len(o_len)
  );

  c_v_stream #(.W(W), .C(C), .P_IS_COMPLIMENT(0)) dut_p0 (
    .clk(clk), .arst_n(arst_n), .i_in_vld(i_in_vld), .i_in_dat(i_in_dat),
    .i_cmp_en(i_cmp_en), .i_flush(i_flush), .i_res_rdy(i_res_rdy),
    .o_in_rdy(p0_in_rdy), .o_res_vld(p0_res_vld), .o_is_unary(p0_is_unary),
    .o_all_set(p0_all_set), .o_is_cmp(p0_is_cmp), .o_len(p0_len)
  );

  typedef struct packed {
    logic          u;
    logic          a;
    logic          c;
    logic [LW-1:0] len;
  } res_t;

  // Reference: try every length against the two unary forms directly.
  function automatic res_t golden(logic [W-1:0] v, logic m, logic p);
    res_t         r;
    logic [W-1:0] one;
    logic [W-1:0] mask;
    r   = '0;
    one = W'(1);
    r.a = (v == {W{1'b1}});
    for (int l = 0; l < int'(W); l++) begin
      mask = (one << l) - one;
      if (v == mask) begin
        r.u   = 1'b1;
        r.len = LW'(l);
      end
      if (p && m && (v == ~mask)) begin
        r.u   = 1'b1;
        r.c   = 1'b1;
        r.len = LW'(l);
      end
    end
    return r;
  endfunction

  // Transaction-level model of the beat stream.
  logic          m_res;
  int unsigned   m_beats;
  logic [W-1:0]  m_vec;
  logic          m_mode;
  res_t          m_out, m_out0;
  logic          m_rdy;
  logic [W-1:0]  m_vec_next;
  logic          m_mode_next;
  res_t          m_exp, m_exp0;

  assign m_rdy       = !i_flush && (!m_res || i_res_rdy);
  assign m_vec_next  = ((m_beats == 0) ? '0 : m_vec) | (W'(i_in_dat) << (m_beats * C));
  assign m_mode_next = (m_beats == 0) ? i_cmp_en : m_mode;
  assign m_exp       = m_res ? m_out : '0;
  assign m_exp0      = m_res ? m_out0 : '0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_res   <= 1'b0;
      m_beats <= 0;
      m_vec   <= '0;
      m_mode  <= 1'b0;
      m_out   <= '0;
      m_out0  <= '0;
    end else if (i_flush) begin
      m_res   <= 1'b0;
      m_beats <= 0;
    end else if (i_in_vld && m_rdy) begin
      if (m_beats == N - 1) begin
        m_res   <= 1'b1;
        m_beats <= 0;
        m_out   <= golden(m_vec_next, m_mode_next, 1'b1);
        m_out0  <= golden(m_vec_next, m_mode_next, 1'b0);
      end else begin
        m_res   <= 1'b0;
        m_beats <= m_beats + 1;
        m_vec   <= m_vec_next;
        m_mode  <= m_mode_next;
      end
    end else if (m_res && i_res_rdy) begin
      m_res <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (arst_n) begin
      chk("cyc_res_vld",  32'(o_res_vld),   32'(m_res));
      chk("cyc_in_rdy",   32'(o_in_rdy),    32'(m_rdy));
      chk("cyc_is_unary", 32'(o_is_unary),  32'(m_exp.u));
      chk("cyc_all_set",  32'(o_all_set),   32'(m_exp.a));
      chk("cyc_is_cmp",   32'(o_is_cmp),    32'(m_exp.c));
      chk("cyc_len",      32'(o_len),       32'(m_exp.len));
      chk("cyc_p0_vld",   32'(p0_res_vld),  32'(m_res));
      chk("cyc_p0_unary", 32'(p0_is_unary), 32'(m_exp0.u));
      chk("cyc_p0_cmp",   32'(p0_is_cmp),   32'(m_exp0.c));
      chk("cyc_p0_len",   32'(p0_len),      32'(m_exp0.len));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait until the model says it transferred.
  task automatic send_beat(input logic [C-1:0] dat, input logic cmp, output int cycles);
    logic a;
    cycles   = 0;
    a        = 1'b0;
    i_in_vld = 1'b1;
    i_in_dat = dat;
    i_cmp_en = cmp;
    while (!a && cycles < 100) begin
      @(negedge clk);
      a = m_rdy;
      tick();
      cycles++;
    end
    if (!a) chk("beat_accept_timeout", 32'(a), 32'd1);
    i_in_vld = 1'b0;
  endtask

  task automatic send_vec(input logic [W-1:0] v, input logic cmp);
    int n;
    for (int k = 0; k < int'(N); k++) begin
      send_beat(v[k*C +: C], cmp, n);
    end
  endtask

  task automatic chk_res(input string tag, input logic u, input logic a, input logic c,
                         input logic [LW-1:0] len);
    chk({tag, "_vld"},   32'(o_res_vld),  32'd1);
    chk({tag, "_unary"}, 32'(o_is_unary), 32'(u));
    chk({tag, "_all"},   32'(o_all_set),  32'(a));
    chk({tag, "_cmp"},   32'(o_is_cmp),   32'(c));
    chk({tag, "_len"},   32'(o_len),      32'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tick();
    tick();
    chk("rst_res_vld", 32'(o_res_vld), 32'd0);
    chk("rst_unary",   32'(o_is_unary), 32'd0);
    chk("rst_len",     32'(o_len), 32'd0);
    arst_n = 1'b1;
    chk("rst_in_rdy_after_release", 32'(o_in_rdy), 32'd1);

    // 0x007F standard, length 7, result one cycle after the last beat
    send_vec(16'h007F, 1'b0);
    chk_res("v007f", 1'b1, 1'b0, 1'b0, LW'(7));
    tick();

    // all-ones: never standard; complement form with length zero
    send_vec(16'hFFFF, 1'b0);
    chk_res("vffff_std", 1'b0, 1'b1, 1'b0, LW'(0));
    tick();
    send_vec(16'hFFFF, 1'b1);
    chk_res("vffff_cmp", 1'b1, 1'b1, 1'b1, LW'(0));
    tick();

    // complemented length 7, rejected when complement is not permitted
    send_vec(16'hFF80, 1'b1);
    chk_res("vff80", 1'b1, 1'b0, 1'b1, LW'(7));
    chk("vff80_p0_unary", 32'(p0_is_unary), 32'd0);
    tick();
    send_vec(16'h0101, 1'b1);
    chk_res("v0101", 1'b0, 1'b0, 1'b0, LW'(0));
    tick();

    // consumer stall, then zero-bubble pop with the next beat 0
    i_res_rdy = 1'b0;
    send_vec(16'h0003, 1'b0);
    repeat (5) tick();
    chk_res("stall", 1'b1, 1'b0, 1'b0, LW'(2));
    chk("stall_in_rdy", 32'(o_in_rdy), 32'd0);
    i_res_rdy = 1'b1;
    send_beat(4'hF, 1'b0, n);
    chk("b2b_beat0_cycles", 32'(n), 32'd1);
    chk("b2b_vld_dropped", 32'(o_res_vld), 32'd0);
    send_beat(4'h1, 1'b0, n);
    send_beat(4'h0, 1'b0, n);
    send_beat(4'h0, 1'b0, n);
    chk_res("b2b_v001f", 1'b1, 1'b0, 1'b0, LW'(5));
    tick();

    // flush after two beats discards them and refuses the beat offered
    send_beat(4'hF, 1'b0, n);
    send_beat(4'hF, 1'b0, n);
    i_flush  = 1'b1;
    i_in_vld = 1'b1;
    i_in_dat = 4'hF;
    @(negedge clk);
    chk("flush_in_rdy", 32'(o_in_rdy), 32'd0);
    tick();
    i_flush  = 1'b0;
    i_in_vld = 1'b0;
    chk("flush_no_vld", 32'(o_res_vld), 32'd0);
    send_vec(16'h0000, 1'b1);
    chk_res("v0000", 1'b1, 1'b0, 1'b0, LW'(0));
    tick();

    // reset pulse after three beats: next four beats are a fresh vector
    send_beat(4'hF, 1'b0, n);
    send_beat(4'hF, 1'b0, n);
    send_beat(4'hF, 1'b0, n);
    arst_n = 1'b0;
    #2;
    chk("arst_vld", 32'(o_res_vld), 32'd0);
    arst_n = 1'b1;
    tick();
    chk("arst_no_vld", 32'(o_res_vld), 32'd0);
    chk("arst_in_rdy", 32'(o_in_rdy), 32'd1);
    send_vec(16'h0007, 1'b0);
    chk_res("arst_v0007", 1'b1, 1'b0, 1'b0, LW'(3));
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
